axi4_rd_arbiter: RTL and testbench
==================================

// Module: axi4_rd_arbiter
// PURPOSE
// - Shares the core's single AXI4 read channel (AR/R) between NUM_MST requesters (icache, dcache, ...).
// - Holds at most one burst in flight; round-robin grant, locked from AR issue until the last R beat.
// - Sits between the cache refill engines and the top-level AXI4 master port; write channels bypass it.
// PARAMETERS
// - NUM_MST     2   number of read requesters (2..8)
// - ADDR_WIDTH  32  address width
// - DATA_WIDTH  32  R data width
// - ID_WIDTH    4   AXI ID width; arid = granted index, zero-extended (needs ID_WIDTH >= clog2(NUM_MST))
// PORTS
// - clk              in   1                    clock, all logic on rising edge
// - a_rst            in   1                    asynchronous active-high reset
// - req_valid        in   NUM_MST              requester has a read burst pending
// - req_ready        out  NUM_MST              request accepted (one-hot, 1-cycle pulse)
// - req_addr         in   NUM_MST*ADDR_WIDTH   burst start address
// - req_len          in   NUM_MST*8            AXI arlen (beats-1)
// - req_size         in   NUM_MST*3            AXI arsize
// - rsp_valid        out  NUM_MST              R beat valid, to the owning requester only
// - rsp_ready        in   NUM_MST              requester can take beat
// - rsp_data         out  DATA_WIDTH           R data, shared bus
// - rsp_resp         out  2                    R response, shared bus
// - rsp_last         out  1                    final beat
// - arid/araddr/arlen/arsize/arburst/arvalid   out  AXI4 AR channel
// - arready          in   1                    AXI4 AR ready
// - rid/rdata/rresp/rlast/rvalid  in  AXI4 R channel;  rready  out  1
// - proto_err        out  1                    1-cycle pulse: rid mismatch or rlast vs beat count mismatch
// BEHAVIOUR
// - Reset: FSM=IDLE, rr_ptr=0, beat_cnt=0; all outputs 0 (arvalid, rready, req_ready, rsp_valid, proto_err, buses).
// - FSM IDLE -> AR -> R -> IDLE.
// - IDLE: if any req_valid, pick first set bit at or after rr_ptr (wrapping); latch addr/len/size/index;
//   pulse req_ready[g] same edge; go AR. No request -> stay, no outputs.
// - AR: arvalid=1 from registers (arburst=INCR, arid=g); hold all AR fields stable until arready;
//   on arvalid&arready -> R, beat_cnt=0. arvalid never drops without handshake.
// - R: rready = rsp_ready[g]; rsp_valid[g] = rvalid; others 0; rsp_data/resp/last = rdata/rresp/rlast
//   (combinational pass-through, 0-cycle latency).
//   Each rvalid&rready: beat_cnt++. Burst ends on the beat where rlast=1:
//   -> IDLE, rr_ptr = (g+1) mod NUM_MST.
// - Min latency: req_valid to arvalid = 1 cycle; back-to-back bursts have 1 IDLE cycle between rlast and next arvalid.
// - Errors:
//   - rid != g on a beat -> proto_err pulse; beat still routed to g (single outstanding).
//   - rlast with beat_cnt != len, or beat_cnt == len without rlast -> proto_err pulse.
//     Termination follows rlast only.
//   - SLVERR/DECERR passed through unchanged; not an arbiter error.
// - Simultaneous: req_valid rising in R state waits; the requester that just completed is lowest priority next round.
// - Requester dropping req_valid after req_ready: no effect, burst already owned.
// - Reset mid-burst: FSM to IDLE at once, AR/R outputs 0.
//   The system resets the interconnect on the same reset.
// - rvalid in IDLE/AR: rready=0, beat ignored, proto_err pulse.
// STRUCTURE
// - Shared package (furina_axi_pkg): AXI_BURST_INCR=2'b01, AXI resp codes, ar_req_t struct {addr,len,size}.
// - Arbiter FSM state enum local to the module.
// - Sub-module rr_arbiter #(N): req vector + rr_ptr -> one-hot grant + index; reused later for write arbitration.
// TESTING
// - Single req: m0 addr=0x1C000000 len=3 -> arvalid next cycle, arid=0, arlen=3, arburst=01;
//   4 beats to m0 only, rsp_last on beat 4, then IDLE.
// - Contention: m0,m1 both valid from reset -> grant m0 first, m1 second; repeat with both
//   held valid -> strict alternation 0,1,0,1.
// - Backpressure: arready low 5 cycles -> AR fields stable.
//   rsp_ready[g] toggling 1/0 -> rready mirrors, no beat lost, beat_cnt=4 at end.
// - Error: rid=1 while g=0 -> proto_err one cycle, data to m0.
//   rlast on beat 2 of len=3 -> proto_err, FSM IDLE.
// - Reset: assert a_rst during beat 2 -> next edge arvalid=rready=rsp_valid=0, FSM IDLE, rr_ptr=0.
// - SLVERR on beat 1 -> rsp_resp=2'b10 to requester, proto_err stays 0.

Source files
------------

// File: rtl/furina_axi_pkg.sv
// Shared AXI4 definitions for the furina core: burst/response codes and the
// latched read-request payload used by the read arbiter.
package furina_axi_pkg;

    localparam int unsigned AXI_ADDR_WIDTH = 32;
    localparam int unsigned AXI_LEN_WIDTH  = 8;
    localparam int unsigned AXI_SIZE_WIDTH = 3;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [AXI_LEN_WIDTH-1:0]  len;
        logic [AXI_SIZE_WIDTH-1:0] size;
    } ar_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
// Purely combinational; the owner keeps and advances the pointer.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] idx_c,
    output logic          any_c
);

    logic [IW:0] cand;
    logic        found;

    // Candidate index walks ptr, ptr+1, ... modulo N
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (IW+1)'(ptr) + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found                 = 1'b1;
                grant_c[cand[IW-1:0]] = 1'b1;
                idx_c                 = cand[IW-1:0];
            end
        end
    end

    assign any_c = |req;

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Shares the single AXI4 AR/R channel between NUM_MST requesters with one
// burst in flight; round-robin grant held from AR issue to the last R beat.
module axi4_rd_arbiter
    import furina_axi_pkg::*;
#(
    parameter int unsigned NUM_MST    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          a_rst,
    input  logic [NUM_MST-1:0]            req_valid,
    output logic [NUM_MST-1:0]            req_ready,
    input  logic [NUM_MST*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_MST*8-1:0]          req_len,
    input  logic [NUM_MST*3-1:0]          req_size,
    output logic [NUM_MST-1:0]            rsp_valid,
    input  logic [NUM_MST-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_last,
    output logic [ID_WIDTH-1:0]           arid,
    output logic [ADDR_WIDTH-1:0]         araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [ID_WIDTH-1:0]           rid,
    input  logic [DATA_WIDTH-1:0]         rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready,
    output logic                          proto_err
);

    localparam int unsigned IDX_W  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int unsigned BEAT_W = AXI_LEN_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]   g_q, g_d;
    ar_req_t            ar_q, ar_d;
    logic [BEAT_W-1:0]  beat_cnt, beat_cnt_d;
    logic [NUM_MST-1:0] req_ready_d;
    logic               proto_err_d;

    logic [NUM_MST-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               in_ar, in_r, r_fire, beat_is_last;

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_MST];
    logic [7:0]            len_arr  [NUM_MST];
    logic [2:0]            size_arr [NUM_MST];

    for (genvar i = 0; i < NUM_MST; i++) begin : g_split
        assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign len_arr[i]  = req_len[i*8 +: 8];
        assign size_arr[i] = req_size[i*3 +: 3];
    end

    rr_arbiter #(
        .N  (NUM_MST),
        .IW (IDX_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant_c (arb_grant),
        .idx_c   (arb_idx),
        .any_c   (arb_any)
    );

    assign in_ar        = (state == ST_AR);
    assign in_r         = (state == ST_R);
    assign r_fire       = in_r && rvalid && rsp_ready[g_q];
    assign beat_is_last = (beat_cnt == BEAT_W'(ar_q.len));

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            g_q       <= '0;
            ar_q      <= '0;
            beat_cnt  <= '0;
            req_ready <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            g_q       <= g_d;
            ar_q      <= ar_d;
            beat_cnt  <= beat_cnt_d;
            req_ready <= req_ready_d;
            proto_err <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        g_d         = g_q;
        ar_d        = ar_q;
        beat_cnt_d  = beat_cnt;
        req_ready_d = '0;
        proto_err_d = 1'b0;
        case (state)
            ST_IDLE: begin
                proto_err_d = rvalid;
                if (arb_any) begin
                    g_d         = arb_idx;
                    ar_d.addr   = AXI_ADDR_WIDTH'(addr_arr[arb_idx]);
                    ar_d.len    = len_arr[arb_idx];
                    ar_d.size   = size_arr[arb_idx];
                    req_ready_d = arb_grant;
                    state_d     = ST_AR;
                end
            end
            ST_AR: begin
                proto_err_d = rvalid;
                if (arready) begin
                    beat_cnt_d = '0;
                    state_d    = ST_R;
                end
            end
            ST_R: begin
                // Beat still goes to the owner on a bad rid; only rlast ends the burst
                if (r_fire) begin
                    beat_cnt_d  = beat_cnt + BEAT_W'(1);
                    proto_err_d = (rid != ID_WIDTH'(g_q)) || (rlast != beat_is_last);
                    if (rlast) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = (g_q == IDX_W'(NUM_MST - 1)) ? '0 : g_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign arvalid = in_ar;
    assign arid    = in_ar ? ID_WIDTH'(g_q) : '0;
    assign araddr  = in_ar ? ADDR_WIDTH'(ar_q.addr) : '0;
    assign arlen   = in_ar ? ar_q.len : '0;
    assign arsize  = in_ar ? ar_q.size : '0;
    assign arburst = in_ar ? AXI_BURST_INCR : 2'b00;

    // R channel is a zero-latency pass-through to the current owner
    assign rready   = in_r && rsp_ready[g_q];
    assign rsp_data = in_r ? rdata : '0;
    assign rsp_resp = in_r ? rresp : '0;
    assign rsp_last = in_r && rlast;

    always_comb begin
        rsp_valid = '0;
        if (in_r && rvalid) begin
            rsp_valid[g_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed bench for axi4_rd_arbiter: a table of full bursts with hand-computed
// grants, plus sequences for backpressure, protocol errors and mid-burst reset.
module tb_axi4_rd_arbiter;
    import furina_axi_pkg::*;

    localparam logic [31:0] A0 = 32'h1C00_0000;
    localparam logic [31:0] A1 = 32'h2000_0040;

    logic        clk;
    logic        a_rst;
    logic [1:0]  req_valid, req_ready;
    logic [63:0] req_addr;
    logic [15:0] req_len;
    logic [5:0]  req_size;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        rsp_last;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready, proto_err;

    int n_chk = 0;
    int n_fail = 0;
    int exp_ptr = 0;
    int exp_beats = 0;

    axi4_rd_arbiter #(
        .NUM_MST(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)
    ) dut (
        .clk(clk), .a_rst(a_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_last(rsp_last),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_data(input int g, input int b);
        return 32'hD000_0000 | (32'(g) << 8) | 32'(b);
    endfunction

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle
    task automatic run_burst(input logic [1:0] mask, input logic [7:0] len,
                             input logic [1:0] resp, input int g);
        req_valid = mask;
        req_len   = {len, len};
        rvalid    = 1'b0;
        rlast     = 1'b0;
        rsp_ready = 2'b00;
        arready   = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 0);
        chk("idle_arvalid", arvalid, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_proto_err", proto_err, 0);
        chk("rr_ptr", dut.rr_ptr, exp_ptr);
        chk("beat_cnt", dut.beat_cnt, exp_beats);
        @(posedge clk); #1;
        arready = 1'b1;
        @(negedge clk);
        chk("req_ready_grant", req_ready, 2'b01 << g);
        chk("arvalid", arvalid, 1);
        chk("arid", arid, g);
        chk("araddr", araddr, (g == 0) ? A0 : A1);
        chk("arlen", arlen, len);
        chk("arsize", arsize, (g == 0) ? 2 : 3);
        chk("arburst", arburst, AXI_BURST_INCR);
        exp_ptr   = (g + 1) % 2;
        exp_beats = int'(len) + 1;
        for (int b = 0; b <= int'(len); b++) begin
            @(posedge clk); #1;
            arready   = 1'b0;
            rsp_ready = 2'b11;
            rvalid    = 1'b1;
            rid       = 4'(g);
            rdata     = beat_data(g, b);
            rresp     = resp;
            rlast     = (b == int'(len));
            @(negedge clk);
            chk("rsp_valid", rsp_valid, 2'b01 << g);
            chk("rready", rready, 1);
            chk("rsp_data", rsp_data, beat_data(g, b));
            chk("rsp_resp", rsp_resp, resp);
            chk("rsp_last", rsp_last, (b == int'(len)) ? 1 : 0);
            chk("beat_proto_err", proto_err, 0);
            chk("beat_arvalid", arvalid, 0);
        end
        @(posedge clk); #1;
    endtask

    // Request, get granted and complete AR; returns at posedge+1 of first R cycle
    task automatic start_burst(input logic [1:0] mask, input logic [7:0] len);
        req_valid = mask;
        req_len   = {len, len};
        @(posedge clk); #1;
        req_valid = 2'b00;
        arready   = 1'b1;
        @(posedge clk); #1;
        arready   = 1'b0;
    endtask

    typedef struct {
        logic [1:0] mask;
        logic [7:0] len;
        logic [1:0] resp;
        int         g;
    } vec_t;

    vec_t vecs[10];
    int   b;
    int   cyc;

    initial begin
        vecs[0] = '{mask: 2'b11, len: 8'd0, resp: AXI_RESP_OKAY,   g: 0};
        vecs[1] = '{mask: 2'b11, len: 8'd1, resp: AXI_RESP_OKAY,   g: 1};
        vecs[2] = '{mask: 2'b11, len: 8'd2, resp: AXI_RESP_OKAY,   g: 0};
        vecs[3] = '{mask: 2'b11, len: 8'd3, resp: AXI_RESP_OKAY,   g: 1};
        vecs[4] = '{mask: 2'b01, len: 8'd3, resp: AXI_RESP_OKAY,   g: 0};
        vecs[5] = '{mask: 2'b10, len: 8'd0, resp: AXI_RESP_OKAY,   g: 1};
        vecs[6] = '{mask: 2'b10, len: 8'd1, resp: AXI_RESP_OKAY,   g: 1};
        vecs[7] = '{mask: 2'b01, len: 8'd0, resp: AXI_RESP_SLVERR, g: 0};
        vecs[8] = '{mask: 2'b01, len: 8'd1, resp: AXI_RESP_DECERR, g: 0};
        vecs[9] = '{mask: 2'b11, len: 8'd2, resp: AXI_RESP_EXOKAY, g: 1};

        a_rst     = 1'b1;
        req_valid = 2'b11;
        req_addr  = {A1, A0};
        req_len   = 16'h0;
        req_size  = {3'd3, 3'd2};
        rsp_ready = 2'b00;
        arready   = 1'b0;
        rid       = 4'h0;
        rdata     = 32'h0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        rvalid    = 1'b0;

        // Reset state with both requesters already pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rr_ptr", dut.rr_ptr, 0);
        chk("rst_beat_cnt", dut.beat_cnt, 0);
        @(posedge clk); #1;
        a_rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_burst(vecs[i].mask, vecs[i].len, vecs[i].resp, vecs[i].g);
        end

        // rvalid while idle: ignored, flagged
        req_valid = 2'b00;
        rvalid    = 1'b1;
        rid       = 4'h0;
        rdata     = 32'h0000_0BAD;
        rlast     = 1'b0;
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("tbl_end_rr_ptr", dut.rr_ptr, 0);
        chk("tbl_end_beat_cnt", dut.beat_cnt, 3);
        chk("idle_rv_rready", rready, 0);
        chk("idle_rv_rsp_valid", rsp_valid, 0);
        chk("idle_rv_rsp_data", rsp_data, 0);
        chk("idle_rv_err_pre", proto_err, 0);
        @(posedge clk); #1;
        rvalid = 1'b0;
        @(negedge clk);
        chk("idle_rv_err", proto_err, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_rv_err_clr", proto_err, 0);

        // AR backpressure, then R backpressure toggling on the owner
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_len   = {8'd3, 8'd3};
        rsp_ready = 2'b00;
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_addr  = {A1, 32'hFFFF_FFF0};
        req_len   = {8'd3, 8'd9};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_arvalid", arvalid, 1);
            chk("bp_araddr", araddr, A0);
            chk("bp_arlen", arlen, 3);
            chk("bp_arid", arid, 0);
            chk("bp_req_ready", req_ready, (i == 0) ? 2'b01 : 2'b00);
            @(posedge clk); #1;
        end
        arready = 1'b1;
        @(negedge clk);
        chk("bp_arvalid_hs", arvalid, 1);
        @(posedge clk); #1;
        arready = 1'b0;
        b   = 0;
        cyc = 0;
        while (b < 4 && cyc < 20) begin
            rvalid    = 1'b1;
            rid       = 4'h0;
            rdata     = beat_data(0, b);
            rresp     = AXI_RESP_OKAY;
            rlast     = (b == 3);
            rsp_ready = (cyc % 2 == 0) ? 2'b01 : 2'b00;
            @(negedge clk);
            chk("bp_rready", rready, rsp_ready[0]);
            chk("bp_rsp_valid", rsp_valid, 2'b01);
            chk("bp_rsp_data", rsp_data, beat_data(0, b));
            chk("bp_proto_err", proto_err, 0);
            if (rsp_ready[0]) b++;
            cyc++;
            @(posedge clk); #1;
        end
        chk("bp_beats_done", b, 4);
        rvalid    = 1'b0;
        rlast     = 1'b0;
        rsp_ready = 2'b00;
        req_addr  = {A1, A0};
        @(negedge clk);
        chk("bp_beat_cnt", dut.beat_cnt, 4);
        chk("bp_rr_ptr", dut.rr_ptr, 1);
        chk("bp_end_err", proto_err, 0);
        chk("bp_end_rready", rready, 0);

        // Wrong rid while owner is m0
        @(posedge clk); #1;
        start_burst(2'b01, 8'd1);
        rvalid    = 1'b1;
        rid       = 4'h1;
        rdata     = beat_data(0, 0);
        rlast     = 1'b0;
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("rid_rsp_valid", rsp_valid, 2'b01);
        chk("rid_rsp_data", rsp_data, beat_data(0, 0));
        chk("rid_err_pre", proto_err, 0);
        @(posedge clk); #1;
        rid   = 4'h0;
        rdata = beat_data(0, 1);
        rlast = 1'b1;
        @(negedge clk);
        chk("rid_err", proto_err, 1);
        chk("rid_rsp_valid2", rsp_valid, 2'b01);
        @(posedge clk); #1;
        rvalid = 1'b0;
        rlast  = 1'b0;
        @(negedge clk);
        chk("rid_err_clr", proto_err, 0);
        chk("rid_idle_rready", rready, 0);

        // Early rlast on beat 2 of a 4-beat burst
        @(posedge clk); #1;
        start_burst(2'b01, 8'd3);
        rvalid = 1'b1;
        rid    = 4'h0;
        rdata  = beat_data(0, 0);
        rlast  = 1'b0;
        @(negedge clk);
        chk("early_err_pre", proto_err, 0);
        @(posedge clk); #1;
        rdata = beat_data(0, 1);
        rlast = 1'b1;
        @(negedge clk);
        chk("early_rsp_last", rsp_last, 1);
        @(posedge clk); #1;
        rvalid = 1'b0;
        rlast  = 1'b0;
        @(negedge clk);
        chk("early_err", proto_err, 1);
        chk("early_idle_rready", rready, 0);
        chk("early_rsp_valid", rsp_valid, 0);
        chk("early_beat_cnt", dut.beat_cnt, 2);
        chk("early_rr_ptr", dut.rr_ptr, 1);

        // Missing rlast on the final beat, then a late rlast
        @(posedge clk); #1;
        start_burst(2'b01, 8'd0);
        rvalid = 1'b1;
        rdata  = beat_data(0, 0);
        rlast  = 1'b0;
        @(negedge clk);
        chk("nolast_err_pre", proto_err, 0);
        @(posedge clk); #1;
        rdata = beat_data(0, 1);
        rlast = 1'b1;
        @(negedge clk);
        chk("nolast_err", proto_err, 1);
        chk("nolast_still_r", rsp_valid, 2'b01);
        @(posedge clk); #1;
        rvalid = 1'b0;
        rlast  = 1'b0;
        @(negedge clk);
        chk("latelast_err", proto_err, 1);
        chk("latelast_idle", rready, 0);
        chk("latelast_beat_cnt", dut.beat_cnt, 2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("latelast_err_clr", proto_err, 0);

        // Reset asserted during beat 2
        @(posedge clk); #1;
        start_burst(2'b01, 8'd3);
        rvalid = 1'b1;
        rdata  = beat_data(0, 0);
        rlast  = 1'b0;
        @(negedge clk);
        chk("mrst_beat1", rsp_valid, 2'b01);
        @(posedge clk); #1;
        rdata = beat_data(0, 1);
        a_rst = 1'b1;
        @(negedge clk);
        chk("mrst_arvalid", arvalid, 0);
        chk("mrst_rready", rready, 0);
        chk("mrst_rsp_valid", rsp_valid, 0);
        chk("mrst_rsp_data", rsp_data, 0);
        chk("mrst_rr_ptr", dut.rr_ptr, 0);
        chk("mrst_beat_cnt", dut.beat_cnt, 0);
        chk("mrst_proto_err", proto_err, 0);
        @(posedge clk); #1;
        a_rst  = 1'b0;
        rvalid = 1'b0;
        exp_ptr   = 0;
        exp_beats = 0;

        // Contention right after reset: m0 first, then m1
        run_burst(2'b11, 8'd0, AXI_RESP_OKAY, 0);
        run_burst(2'b11, 8'd1, AXI_RESP_OKAY, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
